// File: rtl/connect_four_turn_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | connect_four_turn_ctrl: press detect, column heights, turn order |
// | and valid/ready disc writes toward the LED matrix.   Rev 1.0     |
// +------------------------------------------------------------------+
module connect_four_turn_ctrl #(
  parameter int COLS = 7,
  parameter int ROWS = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [COLS-1:0] i_pins,
  input  logic            i_new_game,
  input  logic            i_ready,
  output logic            o_wr_valid,
  output logic [2:0]      o_wr_col,
  output logic [2:0]      o_wr_row,
  output logic            o_wr_player,
  output logic            o_turn,
  output logic [COLS-1:0] o_col_full,
  output logic [5:0]      o_moves,
  output logic            o_game_over,
  output logic            o_reject
);

  localparam logic [2:0] c_ROWS  = 3'(ROWS);
  localparam logic [5:0] c_CELLS = 6'(COLS * ROWS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_OVER = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [COLS-1:0] r_pins;
  logic [COLS-1:0] w_press;
  logic [2:0]      r_height [COLS];
  logic [COLS-1:0] w_col_full;
  logic            r_wr_valid;
  logic [2:0]      r_wr_col;
  logic [2:0]      r_wr_row;
  logic            r_wr_player;
  logic            r_turn;
  logic [5:0]      r_moves;
  logic            r_reject;
  logic [2:0]      w_sel_col;
  logic [2:0]      w_sel_row;
  logic            w_sel_full;
  logic            w_accept;
  logic            w_xfer;
  logic            w_rej;

  assign w_press = i_pins & ~r_pins;

  generate
    for (genvar g = 0; g < COLS; g++) begin : g_full
      assign w_col_full[g] = (r_height[g] == c_ROWS);
    end
  endgenerate

  // Column decode is only meaningful when exactly one press bit is set.
  always_comb begin
    w_sel_col  = 3'd0;
    w_sel_row  = 3'd0;
    w_sel_full = 1'b0;
    for (int i = 0; i < COLS; i++) begin
      if (w_press[i]) begin
        w_sel_col  = 3'(i + 1);
        w_sel_row  = r_height[i];
        w_sel_full = w_col_full[i];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_xfer      = 1'b0;
    w_rej       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_press != '0) begin
          if ($onehot(w_press) && !w_sel_full) begin
            w_accept    = 1'b1;
            w_state_nxt = S_REQ;
          end else begin
            w_rej = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (i_ready) begin
          w_xfer      = 1'b1;
          w_state_nxt = (6'(r_moves + 6'd1) == c_CELLS) ? S_OVER : S_IDLE;
        end
      end
      S_OVER:  w_state_nxt = S_OVER;
      default: w_state_nxt = S_IDLE;
    endcase
    if (i_new_game) begin
      w_state_nxt = S_IDLE;
      w_accept    = 1'b0;
      w_xfer      = 1'b0;
      w_rej       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst || i_new_game) begin
      r_pins      <= '0;
      r_wr_valid  <= 1'b0;
      r_wr_col    <= 3'd0;
      r_wr_row    <= 3'd0;
      r_wr_player <= 1'b0;
      r_turn      <= 1'b0;
      r_moves     <= 6'd0;
      r_reject    <= 1'b0;
      for (int i = 0; i < COLS; i++) r_height[i] <= 3'd0;
    end else begin
      r_pins   <= i_pins;
      r_reject <= w_rej;
      if (w_accept) begin
        r_wr_valid  <= 1'b1;
        r_wr_col    <= w_sel_col;
        r_wr_row    <= w_sel_row;
        r_wr_player <= r_turn;
      end else if (w_xfer) begin
        r_wr_valid <= 1'b0;
        r_moves    <= r_moves + 6'd1;
        r_turn     <= ~r_turn;
        for (int i = 0; i < COLS; i++) begin
          if (3'(i + 1) == r_wr_col && r_height[i] != c_ROWS)
            r_height[i] <= r_height[i] + 3'd1;
        end
      end
    end
  end

  assign o_wr_valid  = r_wr_valid;
  assign o_wr_col    = r_wr_col;
  assign o_wr_row    = r_wr_row;
  assign o_wr_player = r_wr_player;
  assign o_turn      = r_turn;
  assign o_col_full  = w_col_full;
  assign o_moves     = r_moves;
  assign o_game_over = (r_state == S_OVER);
  assign o_reject    = r_reject;

endmodule
`default_nettype wire

// File: tb/tb_connect_four_turn_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_connect_four_turn_ctrl: directed vectors and move sequences   |
// | for connect_four_turn_ctrl.                          Rev 1.0     |
// +------------------------------------------------------------------+
module tb_connect_four_turn_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] pins;
  logic       new_game;
  logic       ready;
  logic       wr_valid;
  logic [2:0] wr_col;
  logic [2:0] wr_row;
  logic       wr_player;
  logic       turn;
  logic [6:0] col_full;
  logic [5:0] moves;
  logic       game_over;
  logic       reject;

  int n_vec  = 0;
  int n_fail = 0;

  int m_height [7];
  int m_turn;
  int m_moves;

  connect_four_turn_ctrl #(.COLS(7), .ROWS(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_pins      (pins),
    .i_new_game  (new_game),
    .i_ready     (ready),
    .o_wr_valid  (wr_valid),
    .o_wr_col    (wr_col),
    .o_wr_row    (wr_row),
    .o_wr_player (wr_player),
    .o_turn      (turn),
    .o_col_full  (col_full),
    .o_moves     (moves),
    .o_game_over (game_over),
    .o_reject    (reject)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] pins;
    logic       ready;
    logic       vld;
    logic [2:0] col;
    logic [2:0] row;
    logic       pl;
    logic       turn;
    logic [5:0] moves;
    logic       rej;
  } vec_t;

  vec_t tbl [14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; pins = '0; new_game = 1'b0; ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 7; i++) m_height[i] = 0;
    m_turn = 0; m_moves = 0;
  endtask

  task automatic press_move(input int col);
    pins = 7'(1 << (col - 1)); ready = 1'b1;
    tick();
    chk("mv_valid", 32'(wr_valid), 32'd1);
    chk("mv_col", 32'(wr_col), 32'(col));
    chk("mv_row", 32'(wr_row), 32'(m_height[col-1]));
    chk("mv_player", 32'(wr_player), 32'(m_turn));
    pins = '0;
    tick();
    m_height[col-1]++; m_moves++; m_turn ^= 1;
    chk("mv_done_valid", 32'(wr_valid), 32'd0);
    chk("mv_moves", 32'(moves), 32'(m_moves));
    chk("mv_turn", 32'(turn), 32'(m_turn));
  endtask

  initial begin
    tbl[0]  = '{7'b0000001, 1'b0, 1'b1, 3'd1, 3'd0, 1'b0, 1'b0, 6'd0, 1'b0};
    tbl[1]  = '{7'b0000000, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1, 6'd1, 1'b0};
    tbl[2]  = '{7'b0000001, 1'b1, 1'b1, 3'd1, 3'd1, 1'b1, 1'b1, 6'd1, 1'b0};
    tbl[3]  = '{7'b0000001, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 6'd2, 1'b0};
    tbl[4]  = '{7'b0000001, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 6'd2, 1'b0};
    tbl[5]  = '{7'b0000000, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 6'd2, 1'b0};
    tbl[6]  = '{7'b0000101, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 6'd2, 1'b1};
    tbl[7]  = '{7'b0000101, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 6'd2, 1'b0};
    tbl[8]  = '{7'b0000000, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 6'd2, 1'b0};
    tbl[9]  = '{7'b0000100, 1'b0, 1'b1, 3'd3, 3'd0, 1'b0, 1'b0, 6'd2, 1'b0};
    tbl[10] = '{7'b0000000, 1'b0, 1'b1, 3'd3, 3'd0, 1'b0, 1'b0, 6'd2, 1'b0};
    tbl[11] = '{7'b0010000, 1'b0, 1'b1, 3'd3, 3'd0, 1'b0, 1'b0, 6'd2, 1'b0};
    tbl[12] = '{7'b0000000, 1'b0, 1'b1, 3'd3, 3'd0, 1'b0, 1'b0, 6'd2, 1'b0};
    tbl[13] = '{7'b0000000, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1, 6'd3, 1'b0};

    do_reset();
    chk("rst_valid", 32'(wr_valid), 32'd0);
    chk("rst_col", 32'(wr_col), 32'd0);
    chk("rst_row", 32'(wr_row), 32'd0);
    chk("rst_turn", 32'(turn), 32'd0);
    chk("rst_full", 32'(col_full), 32'd0);
    chk("rst_moves", 32'(moves), 32'd0);
    chk("rst_over", 32'(game_over), 32'd0);
    chk("rst_reject", 32'(reject), 32'd0);

    for (int v = 0; v < 14; v++) begin
      pins = tbl[v].pins; ready = tbl[v].ready;
      tick();
      chk($sformatf("v%0d_valid", v), 32'(wr_valid), 32'(tbl[v].vld));
      if (tbl[v].vld) begin
        chk($sformatf("v%0d_col", v), 32'(wr_col), 32'(tbl[v].col));
        chk($sformatf("v%0d_row", v), 32'(wr_row), 32'(tbl[v].row));
        chk($sformatf("v%0d_player", v), 32'(wr_player), 32'(tbl[v].pl));
      end
      chk($sformatf("v%0d_turn", v), 32'(turn), 32'(tbl[v].turn));
      chk($sformatf("v%0d_moves", v), 32'(moves), 32'(tbl[v].moves));
      chk($sformatf("v%0d_reject", v), 32'(reject), 32'(tbl[v].rej));
    end

    // Full column: six discs in column 2, then a rejected seventh.
    do_reset();
    for (int k = 0; k < 6; k++) press_move(2);
    chk("full_mask", 32'(col_full), 32'h02);
    pins = 7'b0000010; ready = 1'b1;
    tick();
    chk("full_reject", 32'(reject), 32'd1);
    chk("full_novalid", 32'(wr_valid), 32'd0);
    pins = '0;
    tick();
    chk("full_reject_end", 32'(reject), 32'd0);
    chk("full_novalid2", 32'(wr_valid), 32'd0);
    chk("full_moves", 32'(moves), 32'd6);

    // Held button for 10 cycles yields a single request and transfer.
    do_reset();
    begin
      int n_req;
      n_req = 0;
      pins = 7'b0000001; ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
        tick();
        if (wr_valid) n_req++;
      end
      pins = '0;
      tick();
      chk("held_requests", 32'(n_req), 32'd1);
      chk("held_moves", 32'(moves), 32'd1);
    end

    // Board fill.
    do_reset();
    for (int c = 1; c <= 7; c++) begin
      for (int r = 0; r < 6; r++) begin
        press_move(c);
        if (c == 7 && r == 4) chk("fill41_over", 32'(game_over), 32'd0);
      end
    end
    chk("fill_over", 32'(game_over), 32'd1);
    chk("fill_moves", 32'(moves), 32'd42);
    chk("fill_mask", 32'(col_full), 32'h7f);
    pins = 7'b0000001;
    tick();
    chk("over_novalid", 32'(wr_valid), 32'd0);
    chk("over_noreject", 32'(reject), 32'd0);
    pins = '0; new_game = 1'b1;
    tick();
    new_game = 1'b0;
    chk("ng_valid", 32'(wr_valid), 32'd0);
    chk("ng_col", 32'(wr_col), 32'd0);
    chk("ng_row", 32'(wr_row), 32'd0);
    chk("ng_player", 32'(wr_player), 32'd0);
    chk("ng_turn", 32'(turn), 32'd0);
    chk("ng_full", 32'(col_full), 32'd0);
    chk("ng_moves", 32'(moves), 32'd0);
    chk("ng_over", 32'(game_over), 32'd0);
    chk("ng_reject", 32'(reject), 32'd0);

    // Abort a pending write with new_game.
    do_reset();
    pins = 7'b0001000; ready = 1'b0;
    tick();
    chk("ab_valid", 32'(wr_valid), 32'd1);
    chk("ab_col", 32'(wr_col), 32'd4);
    pins = '0;
    tick();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    chk("ab_dropped", 32'(wr_valid), 32'd0);
    chk("ab_moves", 32'(moves), 32'd0);
    pins = 7'b0001000;
    tick();
    chk("ab_re_valid", 32'(wr_valid), 32'd1);
    chk("ab_re_col", 32'(wr_col), 32'd4);
    chk("ab_re_row", 32'(wr_row), 32'd0);
    pins = '0; ready = 1'b1;
    tick();
    chk("ab_re_moves", 32'(moves), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/connect_four_turn_ctrl.md
Name: connect_four_turn_ctrl

Overview:
- Game sequencer between the debounced column buttons and the LED matrix writer of the four-connect design.
- Detects one column press per turn and tracks the fill height of every column.
- Issues one write request per accepted move to the matrix, using a valid/ready handshake.
- Alternates players, rejects presses into full columns and flags game over when the board is full.

Parameters:
- COLS, 7, number of board columns; legal range 1..7 (column code is 3 bits, 0 reserved for "none").
- ROWS, 6, number of rows per column; legal range 1..7.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- pins  input  COLS  column buttons, bit i = column i+1, level-high while pressed
- new_game  input  1  synchronous board clear, same effect as rst except it takes effect from any state
- ready  input  1  matrix writer can accept a write this cycle
- wr_valid  output  1  write request pending
- wr_col  output  3  column code 1..COLS of pending write
- wr_row  output  3  row 0..ROWS-1 of pending write, 0 = bottom
- wr_player  output  1  owner of pending disc, 0 = player A, 1 = player B
- turn  output  1  player whose move is next
- col_full  output  COLS  bit i high when column i+1 holds ROWS discs
- moves  output  6  accepted moves since reset/new_game
- game_over  output  1  board full, no further moves accepted
- reject  output  1  one-cycle pulse when a press is discarded as illegal

Behaviour:
- Reset values (rst or new_game):
  - state IDLE; all heights 0; pins_r 0.
  - wr_valid 0, wr_col 0, wr_row 0, wr_player 0.
  - turn 0, col_full 0, moves 0, game_over 0, reject 0.
- Edge detect:
  - pins_r registers pins every cycle.
  - press = pins & ~pins_r, evaluated combinationally.
  - Held buttons generate only one press.
- States: IDLE, REQ, OVER.
- IDLE:
  - If press has exactly one bit set (column c) and col_full[c-1]=0:
    - next state REQ.
    - wr_valid=1, wr_col=c, wr_row=height[c-1], wr_player=turn, all registered.
    - Latency: wr_valid is high in the cycle after the clock edge that sees the press.
  - Press on a full column: stay IDLE, reject=1 for one cycle.
  - Press with two or more bits set: stay IDLE, reject=1 for one cycle.
  - press=0: stay IDLE, no pulse.
- REQ:
  - wr_valid, wr_col, wr_row and wr_player are held stable until the handshake.
  - Transfer occurs on a clock edge with wr_valid=1 and ready=1. On that edge:
    - height[c-1]++.
    - col_full[c-1] is set when the new height equals ROWS.
    - moves++ and turn toggles.
    - wr_valid drops.
    - next state is OVER if moves+1 == COLS*ROWS, else IDLE.
  - Presses arriving in REQ are ignored: no queueing, no reject pulse.
  - pins_r still tracks pins, so a button held across REQ does not fire on return to IDLE.
- OVER:
  - game_over=1; all presses ignored.
  - Exit only via rst or new_game.
- Priority: rst > new_game > handshake > press.
  - new_game during REQ abandons the pending write: wr_valid=0 on the next cycle, no height update.
- Width rules:
  - height counters are 3-bit and saturate at ROWS; they never wrap.
  - moves is a 6-bit counter, maximum 42.
- ready is don't-care whenever wr_valid=0.

Test Plan:
- Move and turn alternation: after rst, pulse pins=7'b0000001 for one cycle -> next cycle wr_valid=1, wr_col=1, wr_row=0, wr_player=0. Hold ready=1 -> one transfer, then turn=1, moves=1. Repeat press on column 1 -> wr_row=1, wr_player=1.
- Backpressure: press column 3 with ready=0 for 4 cycles, then ready=1 -> wr_valid high for 4 cycles with wr_col=3 stable, exactly one transfer, moves increments by 1. A column 5 press during the wait produces no request and no reject.
- Full column: 6 accepted presses into column 2 -> col_full=7'b0000010. A 7th press -> reject pulses for exactly 1 cycle, wr_valid stays 0, moves unchanged at 6.
- Illegal press: pins=7'b0000101 rising together -> reject=1 for one cycle, no request. A button held high for 10 cycles yields exactly one request.
- Board full: fill all 42 cells with ready=1 -> game_over=1 after the 42nd transfer, moves=42. Further presses are ignored. new_game -> all outputs return to reset values next cycle.
- Abort: press column 4, keep ready=0, assert new_game -> wr_valid=0 next cycle, height of column 4 still 0. A subsequent press on column 4 -> wr_row=0.
